// File: rtl/relay_pkg.sv
// Shared types and defaults for the relay sequencer.
// Holds the FSM state encoding and parameter defaults.
package relay_pkg;

    localparam int N_RELAY_DEF    = 4;
    localparam int SETTLE_CYC_DEF = 16;
    localparam int CNT_W          = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_FAULT
    } state_t;

endpackage

// File: rtl/relay_if.sv
// Command handshake between a requester and the relay sequencer.
// The requester drives the master side, the sequencer is the slave.
interface relay_if #(
    parameter int IDX_W = 2
);

    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_idx;
    logic             req_on;

    modport master (
        output req_valid,
        output req_idx,
        output req_on,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_idx,
        input  req_on,
        output req_ready
    );

endinterface

// File: rtl/settle_timer.sv
// Down-counter timing contact settle after a coil change.
// Loads a start value, counts down to zero and then holds.
module settle_timer
    import relay_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    assign zero = (count == '0);

    // Load takes priority; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/relay_sequencer.sv
// Relay sequencer: switches one relay coil at a time, waits for
// contacts to settle, verifies feedback and latches a fault.
module relay_sequencer
    import relay_pkg::*;
#(
    parameter int N_RELAY    = N_RELAY_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int IDX_W      = $clog2(N_RELAY)
) (
    input  logic               clk,
    input  logic               rst_n,
    relay_if.slave             req,
    input  logic [N_RELAY-1:0] sense,
    output logic [N_RELAY-1:0] coil,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [IDX_W-1:0]   fault_idx,
    input  logic               clr_fault
);

    state_t             state, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               on_q, on_d;
    logic [N_RELAY-1:0] coil_d;
    logic               done_d;
    logic               fault_d;
    logic [IDX_W-1:0]   fidx_d;
    logic               t_load, t_dec, t_zero;
    logic               idx_ok;

    assign idx_ok        = int'(idx_q) < N_RELAY;
    assign busy          = (state != S_IDLE);
    assign req.req_ready = (state == S_IDLE);

    settle_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (CNT_W'(SETTLE_CYC - 1)),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    // State and datapath registers; reset releases every coil.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx_q     <= '0;
            on_q      <= 1'b0;
            coil      <= '0;
            done      <= 1'b0;
            fault     <= 1'b0;
            fault_idx <= '0;
        end else begin
            state     <= state_d;
            idx_q     <= idx_d;
            on_q      <= on_d;
            coil      <= coil_d;
            done      <= done_d;
            fault     <= fault_d;
            fault_idx <= fidx_d;
        end
    end

    // Next-state and next-output decode for the one command in flight.
    always_comb begin
        state_d = state;
        idx_d   = idx_q;
        on_d    = on_q;
        coil_d  = coil;
        done_d  = 1'b0;
        fault_d = fault;
        fidx_d  = fault_idx;
        t_load  = 1'b0;
        t_dec   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req.req_valid) begin
                    idx_d   = req.req_idx;
                    on_d    = req.req_on;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (!idx_ok) begin
                    state_d = S_IDLE;
                end else if (coil[idx_q] == on_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    coil_d[idx_q] = on_q;
                    t_load        = 1'b1;
                    state_d       = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (t_zero) begin
                    state_d = S_CHECK;
                end else begin
                    t_dec = 1'b1;
                end
            end
            S_CHECK: begin
                if (sense[idx_q] == on_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    fault_d       = 1'b1;
                    fidx_d        = idx_q;
                    coil_d[idx_q] = 1'b0;
                    state_d       = S_FAULT;
                end
            end
            S_FAULT: begin
                if (clr_fault) begin
                    fault_d = 1'b0;
                    fidx_d  = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_relay_sequencer.sv
// Directed self-checking bench for relay_sequencer.
// Default parameters: 4 relays, 16 settle cycles.
module tb_relay_sequencer;

    logic       clk;
    logic       rst_n;
    logic [3:0] sense;
    logic [3:0] coil;
    logic       busy;
    logic       done;
    logic       fault;
    logic [1:0] fault_idx;
    logic       clr_fault;
    logic       sense_tie;
    logic [3:0] sense_frc;

    int n_cmp;
    int n_bad;
    int lat;

    relay_if #(.IDX_W(2)) rif ();

    relay_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (rif.slave),
        .sense     (sense),
        .coil      (coil),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .fault_idx (fault_idx),
        .clr_fault (clr_fault)
    );

    assign sense = sense_tie ? coil : sense_frc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, then wait (bounded) for done or fault.
    task automatic send(input logic [1:0] i, input logic o,
                        output int n);
        rif.req_valid = 1'b1;
        rif.req_idx   = i;
        rif.req_on    = o;
        tick();
        rif.req_valid = 1'b0;
        n = 0;
        while (!done && !fault && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (coil !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_coil: got %b want 0000", coil);
        end
        n_cmp++;
        if (rif.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", rif.req_ready);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_cmp++;
        if (fault !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_fault: got %b want 0", fault);
        end
        n_cmp++;
        if (done !== 1'b0 || fault_idx !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_done_fidx: got %b/%0d want 0/0",
                     done, fault_idx);
        end
    endtask

    task automatic test_change();
        int n;
        sense_tie     = 1'b1;
        rif.req_valid = 1'b1;
        rif.req_idx   = 2'd2;
        rif.req_on    = 1'b1;
        tick();
        rif.req_valid = 1'b0;
        n_cmp++;
        if (coil !== 4'b0000 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL chg_hs: coil %b busy %b want 0000 1",
                     coil, busy);
        end
        tick();
        n = 1;
        n_cmp++;
        if (coil !== 4'b0100) begin
            n_bad++;
            $display("FAIL chg_coil: got %b want 0100", coil);
        end
        while (!done && n < 60) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n !== 18) begin
            n_bad++;
            $display("FAIL chg_latency: got %0d want 18", n);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL chg_pulse: done %b busy %b want 0 0",
                     done, busy);
        end
    endtask

    task automatic test_same_target();
        sense_tie = 1'b1;
        send(2'd1, 1'b1, lat);
        n_cmp++;
        if (lat !== 18) begin
            n_bad++;
            $display("FAIL same_setup_lat: got %0d want 18", lat);
        end
        tick();
        send(2'd1, 1'b1, lat);
        n_cmp++;
        if (lat !== 1 || done !== 1'b1) begin
            n_bad++;
            $display("FAIL same_lat: got %0d/%b want 1/1", lat, done);
        end
        n_cmp++;
        if (coil !== 4'b0110) begin
            n_bad++;
            $display("FAIL same_coil: got %b want 0110", coil);
        end
        tick();
    endtask

    task automatic test_fault();
        sense_tie = 1'b0;
        sense_frc = 4'b0000;
        send(2'd3, 1'b1, lat);
        n_cmp++;
        if (lat !== 18 || fault !== 1'b1) begin
            n_bad++;
            $display("FAIL flt_set: lat %0d fault %b want 18 1",
                     lat, fault);
        end
        n_cmp++;
        if (fault_idx !== 2'd3) begin
            n_bad++;
            $display("FAIL flt_idx: got %0d want 3", fault_idx);
        end
        n_cmp++;
        if (coil !== 4'b0110 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL flt_coil: coil %b done %b want 0110 0",
                     coil, done);
        end
        rif.req_valid = 1'b1;
        rif.req_idx   = 2'd0;
        rif.req_on    = 1'b1;
        tick();
        tick();
        tick();
        n_cmp++;
        if (rif.req_ready !== 1'b0 || fault !== 1'b1 ||
            coil !== 4'b0110) begin
            n_bad++;
            $display("FAIL flt_hold: rdy %b fault %b coil %b want 0 1 0110",
                     rif.req_ready, fault, coil);
        end
        rif.req_valid = 1'b0;
        clr_fault     = 1'b1;
        tick();
        clr_fault = 1'b0;
        n_cmp++;
        if (fault !== 1'b0 || fault_idx !== 2'd0 ||
            rif.req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flt_clr: fault %b fidx %0d rdy %b want 0 0 1",
                     fault, fault_idx, rif.req_ready);
        end
        sense_tie = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [1:0] ci [3];
        logic       co [3];
        int         hs_c [3];
        int         dn_c [3];
        int         cyc;
        int         nhs;
        int         ndn;
        logic       hs;
        ci = '{2'd0, 2'd3, 2'd2};
        co = '{1'b1, 1'b1, 1'b0};
        cyc = 0;
        nhs = 0;
        ndn = 0;
        sense_tie     = 1'b1;
        rif.req_valid = 1'b1;
        rif.req_idx   = ci[0];
        rif.req_on    = co[0];
        while (ndn < 3 && cyc < 200) begin
            hs = rif.req_valid && rif.req_ready;
            n_cmp++;
            if (hs && busy) begin
                n_bad++;
                $display("FAIL b2b_overlap: accepted while busy at %0d",
                         cyc);
            end
            tick();
            cyc++;
            if (hs) begin
                hs_c[nhs] = cyc;
                nhs++;
                if (nhs < 3) begin
                    rif.req_idx = ci[nhs];
                    rif.req_on  = co[nhs];
                end else begin
                    rif.req_valid = 1'b0;
                end
            end
            if (done) begin
                dn_c[ndn] = cyc;
                ndn++;
            end
        end
        rif.req_valid = 1'b0;
        n_cmp++;
        if (ndn !== 3 || nhs !== 3) begin
            n_bad++;
            $display("FAIL b2b_count: done %0d hs %0d want 3 3", ndn, nhs);
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (dn_c[k] - hs_c[k] !== 18) begin
                    n_bad++;
                    $display("FAIL b2b_lat%0d: got %0d want 18",
                             k, dn_c[k] - hs_c[k]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (hs_c[k+1] !== dn_c[k] + 1) begin
                    n_bad++;
                    $display("FAIL b2b_order%0d: hs %0d want %0d",
                             k, hs_c[k+1], dn_c[k] + 1);
                end
            end
        end
        n_cmp++;
        if (coil !== 4'b1011) begin
            n_bad++;
            $display("FAIL b2b_coil: got %b want 1011", coil);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int nd;
        sense_tie     = 1'b1;
        rif.req_valid = 1'b1;
        rif.req_idx   = 2'd2;
        rif.req_on    = 1'b1;
        tick();
        rif.req_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_cmp++;
        if (coil !== 4'b1111 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: coil %b busy %b want 1111 1",
                     coil, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (coil !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_async: coil %b busy %b done %b want 0000 0 0",
                     coil, busy, done);
        end
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) nd++;
        end
        n_cmp++;
        if (nd !== 0) begin
            n_bad++;
            $display("FAIL mid_nodone: got %0d pulses want 0", nd);
        end
        send(2'd2, 1'b1, lat);
        n_cmp++;
        if (lat !== 18 || coil !== 4'b0100) begin
            n_bad++;
            $display("FAIL mid_next: lat %0d coil %b want 18 0100",
                     lat, coil);
        end
        tick();
    endtask

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        clr_fault     = 1'b0;
        sense_tie     = 1'b1;
        sense_frc     = 4'b0000;
        rif.req_valid = 1'b0;
        rif.req_idx   = 2'd0;
        rif.req_on    = 1'b0;
        test_reset();
        test_change();
        test_same_target();
        test_fault();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/relay_sequencer.md
RELAY_SEQUENCER -- requirements
Module: relay_sequencer

Interface
REQ-001 Parameter N_RELAY, default 4: number of relay channels controlled (range 2..16).
REQ-002 Parameter SETTLE_CYC, default 16: cycles allowed for contacts to settle after a coil change (range 1..255).
REQ-003 Parameter IDX_W, default $clog2(N_RELAY): width of the channel index.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  in  1  requester has a switch command pending.
REQ-007 req_ready  out  1  sequencer accepts a command this cycle.
REQ-008 req_idx  in  IDX_W  channel to switch.
REQ-009 req_on  in  1  target state: 1 = coil energised (closed), 0 = released.
REQ-010 sense  in  N_RELAY  contact feedback per channel, 1 = closed; already synchronised by the caller.
REQ-011 coil  out  N_RELAY  registered coil drive per channel.
REQ-012 busy  out  1  high whenever state is not IDLE.
REQ-013 done  out  1  one-cycle pulse when a command completes with matching feedback.
REQ-014 fault  out  1  sticky: set when feedback mismatches after settling.
REQ-015 fault_idx  out  IDX_W  channel that caused the fault.
REQ-016 clr_fault  in  1  one-cycle request to clear the fault and return to IDLE.

Function
REQ-017 FSM states: IDLE, DRIVE, SETTLE, CHECK, FAULT; exactly one coil change is in flight at a time.
REQ-018 req_ready is high only in IDLE; handshake occurs when req_valid and req_ready are both high on a rising edge.
REQ-019 On handshake, latch req_idx and req_on, then go to DRIVE.
REQ-020 A command with req_idx >= N_RELAY is accepted and discarded: no coil change, no done pulse, next state IDLE.
REQ-021 A command whose target equals the current coil bit completes in one cycle: DRIVE -> IDLE with a done pulse, and SETTLE is skipped.
REQ-022 DRIVE: update coil[idx] to the target, load the settle counter with SETTLE_CYC-1, go to SETTLE next cycle.
REQ-023 SETTLE: decrement the counter each cycle; at zero go to CHECK. Dwell in SETTLE is exactly SETTLE_CYC cycles.
REQ-024 CHECK (one cycle): if sense[idx] equals the target, pulse done and go to IDLE; otherwise set fault, load fault_idx, and go to FAULT.
REQ-025 FAULT: coil[fault_idx] is forced to 0 on entry, other coils hold; req_ready stays low; remain here until clr_fault.
REQ-026 clr_fault in FAULT clears fault and fault_idx and goes to IDLE next cycle; clr_fault in any other state has no effect.
REQ-027 Latency from handshake to done for a real change is SETTLE_CYC+2 cycles.
REQ-028 Changes to sense outside CHECK are ignored; only the CHECK-cycle sample matters.

Reset
REQ-029 On rst_n low, immediately: state IDLE, coil all 0, counter 0, done 0, fault 0, fault_idx 0. busy is 0 and req_ready is 1 once rst_n is released.
REQ-030 Reset during SETTLE or FAULT abandons the command and releases all coils without a done pulse.

Structure
REQ-031 The FSM state enum and the SETTLE_CYC/N_RELAY defaults belong in the shared package relay_pkg.
REQ-032 The settle counter is a sub-module, settle_timer (load, decrement, zero flag); everything else stays flat.

Verification
REQ-033 Reset release -> coil=0, req_ready=1, busy=0, fault=0.
REQ-034 Request idx=2 on=1 with sense[2] tied to coil[2] -> coil[2] rises 1 cycle after handshake; done pulses exactly 18 cycles after handshake (SETTLE_CYC=16).
REQ-035 Request idx=1 on=1 while coil[1] is already 1 -> done on the next cycle, no SETTLE dwell.
REQ-036 Request idx=3 on=1 with sense[3] held at 0 -> fault=1, fault_idx=3, coil[3]=0, req_ready stays 0; clr_fault pulse -> IDLE, fault=0.
REQ-037 Back-to-back req_valid held high with 3 commands queued -> each is accepted only in IDLE, never overlaps, and produces 3 done pulses in order.
REQ-038 Assert rst_n low mid-SETTLE -> coil clears asynchronously, no done pulse, and the next command behaves normally.
